// File: rtl/wb_burst_master.sv
// Wishbone classic-cycle burst master: one command becomes 1..2^LEN_WIDTH beats.
// Optional watchdog on unacknowledged strobes is enabled by defining WB_TIMEOUT_EN.
module wb_burst_master #(
  parameter int ADR_WIDTH = 10,
  parameter int DAT_WIDTH = 16,
  parameter int SEL_WIDTH = DAT_WIDTH / 8,
  parameter int LEN_WIDTH = 4,
  parameter int TIMEOUT   = 15
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_we,
  input  logic [ADR_WIDTH-1:0] cmd_adr,
  input  logic [SEL_WIDTH-1:0] cmd_sel,
  input  logic [LEN_WIDTH-1:0] cmd_len,
  input  logic [DAT_WIDTH-1:0] wr_dat,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  output logic [DAT_WIDTH-1:0] rd_dat,
  output logic                 rd_valid,
  output logic                 done,
  output logic                 err,
  output logic                 CYC_O,
  output logic                 STB_O,
  output logic                 WE_O,
  output logic [ADR_WIDTH-1:0] ADR_O,
  output logic [SEL_WIDTH-1:0] SEL_O,
  output logic [DAT_WIDTH-1:0] DAT_O,
  input  logic [DAT_WIDTH-1:0] DAT_I,
  input  logic                 ACK_I,
  input  logic                 ERR_I
);

  typedef enum logic [1:0] {IDLE, WDAT, BUS} state_t;

  state_t               state, next_state;
  logic [LEN_WIDTH-1:0] beats_left;
  logic                 tmo_hit;

`ifdef WB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_cnt;

  // Counts strobe cycles of the current beat; restarts on every ACK/ERR or beat start.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)                                 tmo_cnt <= '0;
    else if (state != BUS || ACK_I || ERR_I)  tmo_cnt <= '0;
    else                                      tmo_cnt <= tmo_cnt + TW'(1);
  end

  assign tmo_hit = (state == BUS) && !ACK_I && !ERR_I && (tmo_cnt == TW'(TIMEOUT - 1));
`else
  // Never fires; the comparison only keeps TIMEOUT referenced in this build.
  assign tmo_hit = (TIMEOUT < 0);
`endif

  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (cmd_valid) next_state = cmd_we ? WDAT : BUS;
      WDAT: if (wr_valid)  next_state = BUS;
      BUS: begin
        if (ERR_I || tmo_hit)          next_state = IDLE;
        else if (ACK_I) begin
          if (beats_left == '0)        next_state = IDLE;
          else                         next_state = WE_O ? WDAT : BUS;
        end
      end
      default:                         next_state = IDLE;
    endcase
  end

  // Handshake and bus-control outputs are registered from next_state, so all of
  // them are flops and read 0 while reset is asserted.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= IDLE;
      cmd_ready <= 1'b0;
      wr_ready  <= 1'b0;
      CYC_O     <= 1'b0;
      STB_O     <= 1'b0;
    end else begin
      state     <= next_state;
      cmd_ready <= (next_state == IDLE);
      wr_ready  <= (next_state == WDAT);
      CYC_O     <= (next_state != IDLE);
      STB_O     <= (next_state == BUS);
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      WE_O       <= 1'b0;
      ADR_O      <= '0;
      SEL_O      <= '0;
      DAT_O      <= '0;
      beats_left <= '0;
      rd_dat     <= '0;
      rd_valid   <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      case (state)
        IDLE: if (cmd_valid) begin
          WE_O       <= cmd_we;
          ADR_O      <= cmd_adr;
          SEL_O      <= cmd_sel;
          beats_left <= cmd_len;
        end
        WDAT: if (wr_valid) DAT_O <= wr_dat;
        BUS: begin
          // ERR_I takes priority: the beat is abandoned and nothing is returned.
          if (ERR_I || tmo_hit) begin
            done <= 1'b1;
            err  <= 1'b1;
          end else if (ACK_I) begin
            if (!WE_O) begin
              rd_dat   <= DAT_I;
              rd_valid <= 1'b1;
            end
            if (beats_left == '0) begin
              done <= 1'b1;
            end else begin
              ADR_O      <= ADR_O + ADR_WIDTH'(1);
              beats_left <= beats_left - LEN_WIDTH'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_burst_master.sv
// Directed testbench for wb_burst_master; the slave side is driven step by step.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_wb_burst_master;

  logic        CLK = 1'b0;
  logic        RST;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [9:0]  cmd_adr;
  logic [1:0]  cmd_sel;
  logic [3:0]  cmd_len;
  logic [15:0] wr_dat;
  logic        wr_valid, wr_ready;
  logic [15:0] rd_dat;
  logic        rd_valid, done, err;
  logic        CYC_O, STB_O, WE_O;
  logic [9:0]  ADR_O;
  logic [1:0]  SEL_O;
  logic [15:0] DAT_O, DAT_I;
  logic        ACK_I, ERR_I;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  wb_burst_master dut (
    .CLK(CLK), .RST(RST),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_adr(cmd_adr), .cmd_sel(cmd_sel), .cmd_len(cmd_len),
    .wr_dat(wr_dat), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_dat(rd_dat), .rd_valid(rd_valid), .done(done), .err(err),
    .CYC_O(CYC_O), .STB_O(STB_O), .WE_O(WE_O),
    .ADR_O(ADR_O), .SEL_O(SEL_O), .DAT_O(DAT_O),
    .DAT_I(DAT_I), .ACK_I(ACK_I), .ERR_I(ERR_I)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic issue(input logic we, input logic [9:0] adr, input logic [3:0] len);
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_adr   = adr;
    cmd_sel   = 2'b11;
    cmd_len   = len;
  endtask

  logic [9:0]  exp_adr[4];
  logic [15:0] exp_rd[4];
  logic        hold_ok;

  initial begin
    exp_adr = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
    exp_rd  = '{16'h1000, 16'h1001, 16'h1002, 16'h1003};
    RST = 1'b0; cmd_valid = 0; cmd_we = 0; cmd_adr = '0; cmd_sel = '0; cmd_len = '0;
    wr_dat = '0; wr_valid = 0; DAT_I = '0; ACK_I = 0; ERR_I = 0;

    // Reset: every output 0 before any clock edge.
    #3;
    check("reset_outputs", {cmd_ready, wr_ready, rd_valid, done, err, CYC_O, STB_O, WE_O,
                            ADR_O, SEL_O, DAT_O, rd_dat}, 64'h0);
    tick(); tick();
    RST = 1'b1;
    tick();
    check("idle_ready", {cmd_ready, CYC_O}, 2'b10);

    // 1: single write, ACK after one wait state.
    issue(1'b1, 10'h155, 4'd0);
    wr_valid = 1'b1; wr_dat = 16'hA5C3;
    tick();
    check("t1_wdat", {CYC_O, STB_O, wr_ready, cmd_ready}, 4'b1010);
    cmd_valid = 1'b0;
    tick();
    check("t1_bus", {CYC_O, STB_O, WE_O, ADR_O, SEL_O, DAT_O}, {3'b111, 10'h155, 2'b11, 16'hA5C3});
    wr_valid = 1'b0;
    tick();
    check("t1_wait", {CYC_O, STB_O, done}, 3'b110);
    ACK_I = 1'b1;
    tick();
    check("t1_done", {done, err, CYC_O, STB_O, cmd_ready, rd_valid}, 6'b100010);
    check("t1_hold", {WE_O, ADR_O, DAT_O}, {1'b1, 10'h155, 16'hA5C3});
    ACK_I = 1'b0;
    tick();
    check("t1_pulse", done, 1'b0);

    // 2: 4-beat read across the address wrap, zero-wait slave.
    issue(1'b0, 10'h3FE, 4'd3);
    for (int i = 0; i < 4; i++) begin
      tick();
      cmd_valid = 1'b0;
      check("t2_adr", {CYC_O, STB_O, WE_O, done, ADR_O}, {4'b1100, exp_adr[i]});
      if (i > 0) check("t2_rd", {rd_valid, rd_dat}, {1'b1, exp_rd[i-1]});
      ACK_I = 1'b1;
      DAT_I = exp_rd[i];
    end
    tick();
    check("t2_last", {rd_valid, rd_dat, done, err, CYC_O}, {1'b1, 16'h1003, 3'b100});
    ACK_I = 1'b0;

    // 3: 4-beat write, ERR_I together with ACK_I on beat 2.
    issue(1'b1, 10'h010, 4'd3);
    wr_valid = 1'b1; wr_dat = 16'h1111;
    tick();
    cmd_valid = 1'b0;
    check("t3_wdat1", {CYC_O, STB_O, wr_ready}, 3'b101);
    tick();
    check("t3_beat1", {STB_O, ADR_O, DAT_O}, {1'b1, 10'h010, 16'h1111});
    ACK_I = 1'b1; wr_dat = 16'h2222;
    tick();
    check("t3_wdat2", {CYC_O, STB_O, wr_ready}, 3'b101);
    ACK_I = 1'b0;
    tick();
    check("t3_beat2", {STB_O, ADR_O, DAT_O}, {1'b1, 10'h011, 16'h2222});
    ACK_I = 1'b1; ERR_I = 1'b1;
    tick();
    check("t3_err", {done, err, CYC_O, STB_O, wr_ready}, 5'b11000);
    ACK_I = 1'b0; ERR_I = 1'b0;
    tick();
    check("t3_after", {done, err, CYC_O, STB_O, wr_ready, ADR_O}, {5'b00000, 10'h011});
    wr_valid = 1'b0;

    // 4: write data stalls mid-burst; CYC_O stays up with STB_O low.
    issue(1'b1, 10'h020, 4'd1);
    wr_valid = 1'b1; wr_dat = 16'h3333;
    tick();
    cmd_valid = 1'b0;
    tick();
    check("t4_beat1", {STB_O, ADR_O, DAT_O}, {1'b1, 10'h020, 16'h3333});
    ACK_I = 1'b1; wr_valid = 1'b0;
    hold_ok = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      ACK_I = 1'b0;
      if (!(CYC_O && !STB_O && wr_ready && !done)) hold_ok = 1'b0;
    end
    check("t4_stall", hold_ok, 1'b1);
    wr_valid = 1'b1; wr_dat = 16'h4444;
    tick();
    check("t4_beat2", {STB_O, ADR_O, DAT_O}, {1'b1, 10'h021, 16'h4444});
    wr_valid = 1'b0; ACK_I = 1'b1;
    tick();
    check("t4_done", {done, err, CYC_O}, 3'b100);
    ACK_I = 1'b0;

    // 5: slave never answers.
    issue(1'b0, 10'h030, 4'd0);
    hold_ok = 1'b1;
    for (int k = 0; k < 15; k++) begin
      tick();
      cmd_valid = 1'b0;
      if (!(CYC_O && STB_O && !done)) hold_ok = 1'b0;
    end
    check("t5_strobe15", hold_ok, 1'b1);
`ifdef WB_TIMEOUT_EN
    tick();
    check("t5_timeout", {done, err, CYC_O, STB_O, rd_valid}, 5'b11000);
`else
    for (int k = 15; k < 100; k++) begin
      tick();
      if (!(CYC_O && STB_O && !done)) hold_ok = 1'b0;
    end
    check("t5_strobe100", hold_ok, 1'b1);
    ACK_I = 1'b1; DAT_I = 16'h5555;
    tick();
    check("t5_late_ack", {done, err, rd_valid, rd_dat, CYC_O}, {3'b101, 16'h5555, 1'b0});
    ACK_I = 1'b0;
`endif

    // 6: asynchronous reset in the middle of a read burst.
    tick();
    issue(1'b0, 10'h040, 4'd3);
    tick();
    cmd_valid = 1'b0;
    ACK_I = 1'b1; DAT_I = 16'h7000;
    tick();
    check("t6_mid", {CYC_O, STB_O, ADR_O}, {2'b11, 10'h041});
    #2 RST = 1'b0;
    ACK_I = 1'b0;
    #1;
    check("t6_async", {cmd_ready, wr_ready, rd_valid, done, err, CYC_O, STB_O, WE_O,
                       ADR_O, SEL_O, DAT_O, rd_dat}, 64'h0);
    tick();
    RST = 1'b1;
    tick();
    check("t6_release", {cmd_ready, done, err, CYC_O}, 4'b1000);
    issue(1'b0, 10'h050, 4'd0);
    tick();
    cmd_valid = 1'b0;
    check("t6_new_bus", {CYC_O, STB_O, ADR_O}, {2'b11, 10'h050});
    ACK_I = 1'b1; DAT_I = 16'h6666;
    tick();
    check("t6_new_done", {rd_valid, rd_dat, done, err, CYC_O}, {1'b1, 16'h6666, 3'b100});
    ACK_I = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
